cp0_unit: RTL

Coprocessor-0 for the pipelined MIPS CPU. It sits directly downstream of the timers: it consumes their IRQ outputs together with the external interrupt line. It also holds the SR, Cause, EPC and PRId registers for mfc0/mtc0. It raises a single exception/interrupt request that redirects the pipeline to the handler and supplies EPC for eret.

---
 rtl/cp0_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId register file, interrupt and exception
// request generation, and EPC capture for the handler redirect and eret.
module cp0_unit #(
  parameter logic [31:0] PRID = 32'h0000_4353
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  RdAddr,
  input  logic [4:0]  WrAddr,
  input  logic        WE,
  input  logic [31:0] Din,
  input  logic [31:0] PC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCode,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        Req,
  output logic [31:0] EPCOut,
  output logic [31:0] Dout
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // HWInt[0] is interrupt line 2, so it lines up with IM[10] and IP[10].
  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] pc_victim;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic        wr_sr;
  logic        wr_epc;

  assign int_req = ie & ~exl & (|(HWInt & im));
  assign exc_req = (ExcCode != 5'd0) & ~exl;
  assign Req     = int_req | exc_req;

  // A branch-delay-slot victim resumes at its branch.
  assign pc_victim = BDIn ? (PC - 32'd4) : PC;

  assign wr_sr  = WE && (WrAddr == ADDR_SR);
  assign wr_epc = WE && (WrAddr == ADDR_EPC);

  // Later assignments in this block take precedence, so the statement order
  // below encodes mtc0 < EXLClr < Req.
  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= HWInt;
      if (wr_sr) begin
        im  <= Din[15:10];
        exl <= Din[1];
        ie  <= Din[0];
      end
      if (wr_epc) begin
        epc <= {Din[31:2], 2'b00};
      end
      if (EXLClr) begin
        exl <= 1'b0;
      end
      if (Req) begin
        exl      <= 1'b1;
        bd       <= BDIn;
        epc      <= {pc_victim[31:2], 2'b00};
        exc_code <= int_req ? 5'd0 : ExcCode;
      end
    end
  end

  assign sr_word    = {16'd0, im, 8'd0, exl, ie};
  assign cause_word = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
  assign EPCOut     = epc;

  always_comb begin
    Dout = '0;
    case (RdAddr)
      ADDR_SR:    Dout = sr_word;
      ADDR_CAUSE: Dout = cause_word;
      ADDR_EPC:   Dout = epc;
      ADDR_PRID:  Dout = PRID;
      default:    Dout = '0;
    endcase
  end

endmodule
